// File: rtl/slave_port_v3_pkg.sv
// Shared types and elaboration-time helpers for the slave_port_v3 serial slave.
// Optional feature macro: SLAVE_SPLIT_EN (adds the SPLIT state).
package slave_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WDATA,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RWAIT,
`ifdef SLAVE_SPLIT_EN
        ST_SPLIT,
`endif
        ST_SEND
    } state_e;

    // Serial beats needed to move the {addr, len} header.
    function automatic int hdr_beats(input int addr_w, input int len_w, input int lanes);
        return (addr_w + len_w) / lanes;
    endfunction

    // Serial beats needed to move one RAM word.
    function automatic int data_beats(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

    // Bits needed for a counter running 0..n-1.
    function automatic int count_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // True when the width parameters split evenly into serial beats.
    function automatic bit params_legal(input int addr_w, input int data_w, input int len_w,
                                        input int lanes, input int rd_lat);
        return (lanes >= 1) && (rd_lat >= 1) &&
               ((data_w % lanes) == 0) && (((addr_w + len_w) % lanes) == 0);
    endfunction

endpackage

// File: rtl/slave_port_v3_if.sv
// Serial master link between the bus interconnect and slave_port_v3.
// Optional feature macro: SLAVE_SPLIT_EN (split / split_grant carry meaning only then).
interface slave_port_v3_if #(
    parameter int LANES = 1
);
    logic             mode;
    logic [LANES-1:0] wr_bus;
    logic             master_valid;
    logic             master_ready;
    logic [LANES-1:0] rd_bus;
    logic             slave_ready;
    logic             slave_valid;
    logic             split;
    logic             split_grant;

    modport slave (
        input  mode, wr_bus, master_valid, master_ready, split_grant,
        output rd_bus, slave_ready, slave_valid, split
    );

    modport master (
        output mode, wr_bus, master_valid, master_ready, split_grant,
        input  rd_bus, slave_ready, slave_valid, split
    );
endinterface

// File: rtl/slave_port_v3_serial_shift_lane.sv
// LANES-wide load/shift register: parallel load has priority over shift,
// data enters at the LSB end and leaves MSB group first.
module serial_shift_lane #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic [LANES-1:0] ser_i,
    output logic [WIDTH-1:0] data_o,
    output logic [LANES-1:0] ser_o
);
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] shifted;

    if (WIDTH == LANES) begin : g_one_beat
        assign shifted = ser_i;
    end else begin : g_multi_beat
        assign shifted = {data_q[WIDTH-LANES-1:0], ser_i};
    end

    // Next value: load wins over shift, otherwise hold.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = shifted;
        end
    end

    // Register with asynchronous clear.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign ser_o  = data_q[WIDTH-1 -: LANES];
endmodule

// File: rtl/slave_port_v3.sv
// Serial-bus slave front end: bit-serial master link to a word-wide synchronous RAM,
// with LANES-wide beats, bursts with address auto-increment and wrap.
// Optional feature macro: SLAVE_SPLIT_EN (split read path with explicit re-grant).
module slave_port_v3
    import slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int LANES        = 1,
    parameter int LEN_WIDTH    = 4,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    slave_port_v3_if.slave        bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);
    localparam int HDR_W      = ADDR_WIDTH + LEN_WIDTH;
    localparam int HDR_BEATS  = hdr_beats(ADDR_WIDTH, LEN_WIDTH, LANES);
    localparam int DATA_BEATS = data_beats(DATA_WIDTH, LANES);
    localparam int BEAT_W     = count_width((HDR_BEATS > DATA_BEATS) ? HDR_BEATS : DATA_BEATS);
    localparam int LAT_W      = count_width(READ_LATENCY);

    localparam logic [BEAT_W-1:0] HDR_LAST  = BEAT_W'(HDR_BEATS - 1);
    localparam logic [BEAT_W-1:0] DATA_LAST = BEAT_W'(DATA_BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    if (!params_legal(ADDR_WIDTH, DATA_WIDTH, LEN_WIDTH, LANES, READ_LATENCY)) begin : g_bad_params
        $error("slave_port_v3: widths must split evenly into LANES-bit beats and READ_LATENCY >= 1");
    end

    state_e              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                mode_q, mode_d;

    logic                hdr_load, hdr_shift, wd_shift, rd_load, rd_shift;
    logic [HDR_W-1:0]    hdr_word, hdr_reload;
    logic [LEN_WIDTH-1:0] cur_len;
    logic [LANES-1:0]    hdr_ser, wd_ser;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                slave_ready_c, slave_valid_c, split_c, wr_en_c, rd_en_c;

`ifdef SLAVE_SPLIT_EN
    logic                data_ready_q, data_ready_d;
`else
    logic                unused_split_grant;
    assign unused_split_grant = bus.split_grant;
`endif

    logic unused_taps;
    assign unused_taps = ^{hdr_ser, wd_ser, rd_word};

    // The header register doubles as the live {addr, len} pair of the burst.
    assign ram_addr   = hdr_word[HDR_W-1:LEN_WIDTH];
    assign cur_len    = hdr_word[LEN_WIDTH-1:0];
    assign hdr_reload = {ADDR_WIDTH'(ram_addr + 1'b1), LEN_WIDTH'(cur_len - 1'b1)};

    serial_shift_lane #(.WIDTH(HDR_W), .LANES(LANES)) u_hdr (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (hdr_load),
        .load_data_i(hdr_reload),
        .shift_i    (hdr_shift),
        .ser_i      (bus.wr_bus),
        .data_o     (hdr_word),
        .ser_o      (hdr_ser)
    );

    serial_shift_lane #(.WIDTH(DATA_WIDTH), .LANES(LANES)) u_wdata (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (1'b0),
        .load_data_i('0),
        .shift_i    (wd_shift),
        .ser_i      (bus.wr_bus),
        .data_o     (ram_wdata),
        .ser_o      (wd_ser)
    );

    serial_shift_lane #(.WIDTH(DATA_WIDTH), .LANES(LANES)) u_rdata (
        .clk        (clk),
        .rstn       (rstn),
        .load_i     (rd_load),
        .load_data_i(ram_rdata),
        .shift_i    (rd_shift),
        .ser_i      ('0),
        .data_o     (rd_word),
        .ser_o      (bus.rd_bus)
    );

    // Next-state, counter updates and handshake/strobe outputs.
    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        mode_d        = mode_q;
        hdr_load      = 1'b0;
        hdr_shift     = 1'b0;
        wd_shift      = 1'b0;
        rd_load       = 1'b0;
        rd_shift      = 1'b0;
        slave_ready_c = 1'b0;
        slave_valid_c = 1'b0;
        split_c       = 1'b0;
        wr_en_c       = 1'b0;
        rd_en_c       = 1'b0;
`ifdef SLAVE_SPLIT_EN
        data_ready_d  = data_ready_q;
`endif
        case (state_q)
            ST_IDLE: begin
                beat_cnt_d = '0;
                if (bus.master_valid) begin
                    mode_d  = bus.mode;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                slave_ready_c = 1'b1;
                if (!bus.master_valid) begin
                    beat_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    hdr_shift = 1'b1;
                    if (beat_cnt_q == HDR_LAST) begin
                        beat_cnt_d = '0;
                        state_d    = mode_q ? ST_WDATA : ST_RD_ISSUE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                slave_ready_c = 1'b1;
                if (!bus.master_valid) begin
                    beat_cnt_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    wd_shift = 1'b1;
                    if (beat_cnt_q == DATA_LAST) begin
                        beat_cnt_d = '0;
                        state_d    = ST_WRITE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                wr_en_c = 1'b1;
                if (cur_len != '0) begin
                    hdr_load = 1'b1;
                    state_d  = ST_WDATA;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                rd_en_c   = 1'b1;
                lat_cnt_d = '0;
                state_d   = ST_RWAIT;
`ifdef SLAVE_SPLIT_EN
                data_ready_d = 1'b0;
`endif
            end
            ST_RWAIT: begin
`ifdef SLAVE_SPLIT_EN
                if (READ_LATENCY > 2) begin
                    // Long latency: release the bus and keep counting while split.
                    lat_cnt_d = lat_cnt_q + 1'b1;
                    state_d   = ST_SPLIT;
                end else
`endif
                if (lat_cnt_q == LAT_LAST) begin
                    rd_load    = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = ST_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
`ifdef SLAVE_SPLIT_EN
            ST_SPLIT: begin
                split_c = 1'b1;
                if (!data_ready_q) begin
                    // Grants arriving before the word is captured are ignored.
                    if (lat_cnt_q == LAT_LAST) begin
                        rd_load      = 1'b1;
                        data_ready_d = 1'b1;
                    end else begin
                        lat_cnt_d = lat_cnt_q + 1'b1;
                    end
                end else if (bus.split_grant) begin
                    beat_cnt_d = '0;
                    state_d    = ST_SEND;
                end
            end
`endif
            ST_SEND: begin
                slave_valid_c = 1'b1;
                if (bus.master_ready) begin
                    rd_shift = 1'b1;
                    if (beat_cnt_q == DATA_LAST) begin
                        beat_cnt_d = '0;
                        if (cur_len != '0) begin
                            hdr_load = 1'b1;
                            state_d  = ST_RD_ISSUE;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and latched mode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            lat_cnt_q    <= '0;
            mode_q       <= 1'b0;
`ifdef SLAVE_SPLIT_EN
            data_ready_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            mode_q       <= mode_d;
`ifdef SLAVE_SPLIT_EN
            data_ready_q <= data_ready_d;
`endif
        end
    end

    assign bus.slave_ready = slave_ready_c;
    assign bus.slave_valid = slave_valid_c;
    assign bus.split       = split_c;
    assign ram_wr_en       = wr_en_c;
    assign ram_rd_en       = rd_en_c;
endmodule

// File: tb/tb_slave_port_v3.sv
// Scoreboard bench for slave_port_v3 (LANES=4, READ_LATENCY=4).
// Optional feature macro: SLAVE_SPLIT_EN enables the split/grant and reset-in-split section.
module tb_slave_port_v3;
    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int LANES  = 4;
    localparam int LW     = 4;
    localparam int RL     = 4;
    localparam int HBEATS = (AW + LW) / LANES;
    localparam int DBEATS = DW / LANES;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wr_en;
    logic          ram_rd_en;
    logic [DW-1:0] ram_rdata;

    slave_port_v3_if #(.LANES(LANES)) bus ();

    slave_port_v3 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LANES), .LEN_WIDTH(LW), .READ_LATENCY(RL)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wr_en(ram_wr_en),
        .ram_rd_en(ram_rd_en),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_ra[$];
    logic [LANES-1:0] exp_beat[$];

    logic [DW-1:0] ram_mem [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    logic [DW-1:0] rd_pipe [RL];
    logic [DW-1:0] wbuf [16];
    bit            split_chk_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: write on strobe, read data appears RL cycles after ram_rd_en.
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= ram_rd_en ? ram_mem[ram_addr] : DW'($urandom);
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RL-1];

    // Monitor: pops expectations whenever the DUT strobes RAM or retires a read beat.
    logic             prev_stall = 1'b0;
    logic [LANES-1:0] prev_rd = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall <= 1'b0;
        end else begin
            if (ram_wr_en || ram_rd_en)
                check("one_strobe", {31'd0, ram_wr_en & ram_rd_en}, 32'd0);
            if (ram_wr_en) begin
                check("wr_pending", {31'd0, exp_wr.size() > 0}, 32'd1);
                if (exp_wr.size() > 0) begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("wr_addr", {16'd0, ram_addr}, {16'd0, w.addr});
                    check("wr_data", {24'd0, ram_wdata}, {24'd0, w.data});
                end
            end
            if (ram_rd_en) begin
                check("rd_pending", {31'd0, exp_ra.size() > 0}, 32'd1);
                if (exp_ra.size() > 0) check("rd_addr", {16'd0, ram_addr}, {16'd0, exp_ra.pop_front()});
            end
            if (prev_stall) begin
                check("stall_valid_held", {31'd0, bus.slave_valid}, 32'd1);
                check("stall_data_held", {28'd0, bus.rd_bus}, {28'd0, prev_rd});
            end
            if (bus.slave_valid && bus.master_ready) begin
                check("beat_pending", {31'd0, exp_beat.size() > 0}, 32'd1);
                if (exp_beat.size() > 0) check("rd_beat", {28'd0, bus.rd_bus}, {28'd0, exp_beat.pop_front()});
            end
`ifndef SLAVE_SPLIT_EN
            if (bus.slave_valid) check("split_tied_low", {31'd0, bus.split}, 32'd0);
`endif
            prev_stall <= bus.slave_valid && !bus.master_ready;
            prev_rd    <= bus.rd_bus;
        end
    end

    // Read-side master: mostly ready, with occasional 3-cycle stalls.
    initial begin
        int stall_left;
        stall_left = 0;
        bus.master_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_left > 0) begin
                bus.master_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(3) == 0) begin
                bus.master_ready = 1'b0;
                stall_left = 2;
            end else begin
                bus.master_ready = 1'b1;
            end
        end
    end

    // Bus arbiter: early grant pulse (must be ignored), real grant 7 cycles after issue.
    initial begin
        bus.split_grant = 1'b0;
`ifdef SLAVE_SPLIT_EN
        forever begin
            @(negedge clk);
            if (rstn && ram_rd_en) begin
                for (int j = 1; j <= 8; j++) begin
                    @(posedge clk); #1;
                    bus.split_grant = (j == 2) || (j == 7);
                    @(negedge clk);
                    if (split_chk_en && rstn) begin
                        if (j >= 2 && j <= 7) begin
                            check("split_high", {31'd0, bus.split}, 32'd1);
                            check("no_valid_in_split", {31'd0, bus.slave_valid}, 32'd0);
                        end
                        if (j == 8) begin
                            check("split_low_after_grant", {31'd0, bus.split}, 32'd0);
                            check("valid_after_grant", {31'd0, bus.slave_valid}, 32'd1);
                        end
                    end
                end
                bus.split_grant = 1'b0;
            end
        end
`endif
    end

    task automatic send_beat(input logic [LANES-1:0] v);
        bit acc;
        int n;
        bus.wr_bus       = v;
        bus.master_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.slave_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) check("beat_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_header(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input int nbeats);
        logic [AW+LW-1:0] h, s;
        bus.mode = wr;
        h = {addr, len};
        for (int k = 0; k < nbeats; k++) begin
            s = h >> (LANES * (HBEATS - 1 - k));
            send_beat(s[LANES-1:0]);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_wr.size() + exp_ra.size() + exp_beat.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", {31'd0, n < 3000}, 32'd1);
        repeat (3) @(negedge clk);
        check("idle_after", {30'd0, bus.slave_ready, bus.slave_valid}, 32'd0);
    endtask

    // Reference model: one word per burst index, address wraps at 2^AW.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        logic [AW-1:0] a;
        logic [DW-1:0] b, s;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            if (wr) begin
                exp_wr.push_back('{a, wbuf[i]});
                ref_mem[a] = wbuf[i];
            end else begin
                exp_ra.push_back(a);
                b = ref_mem[a];
                for (int k = 0; k < DBEATS; k++) begin
                    s = b >> (LANES * (DBEATS - 1 - k));
                    exp_beat.push_back(s[LANES-1:0]);
                end
            end
        end
        send_header(wr, addr, len, HBEATS);
        if (wr) begin
            for (int i = 0; i <= int'(len); i++) begin
                for (int k = 0; k < DBEATS; k++) begin
                    b = wbuf[i] >> (LANES * (DBEATS - 1 - k));
                    send_beat(b[LANES-1:0]);
                end
            end
        end
        bus.master_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [LW-1:0] rl;
        bus.mode = 1'b0;
        bus.wr_bus = '0;
        bus.master_valid = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            ram_mem[i] = DW'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        for (int i = 0; i < RL; i++) rd_pipe[i] = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_addr", {16'd0, ram_addr}, 32'd0);
        check("rst_wdata", {24'd0, ram_wdata}, 32'd0);
        check("rst_outputs", {25'd0, ram_wr_en, ram_rd_en, bus.slave_ready, bus.slave_valid,
                              bus.split, bus.rd_bus == '0}, 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Single-word write.
        wbuf[0] = 8'hA5;
        run_txn(1'b1, 16'h0012, 4'd0);

        // Read burst crossing 0x00FF -> 0x0100.
        ram_mem[16'h00FE] = 8'h11; ref_mem[16'h00FE] = 8'h11;
        ram_mem[16'h00FF] = 8'h22; ref_mem[16'h00FF] = 8'h22;
        ram_mem[16'h0100] = 8'h33; ref_mem[16'h0100] = 8'h33;
        run_txn(1'b0, 16'h00FE, 4'd2);

        // Write burst wrapping 0xFFFF -> 0x0000, then read it back.
        wbuf[0] = 8'h5C; wbuf[1] = 8'hC3;
        run_txn(1'b1, 16'hFFFF, 4'd1);
        run_txn(1'b0, 16'hFFFF, 4'd1);
        run_txn(1'b0, 16'h0012, 4'd0);

        // Header aborted after 3 beats: no RAM access.
        send_header(1'b0, 16'h0200, 4'd0, 3);
        bus.master_valid = 1'b0;
        wait_idle();

        // Write aborted mid-word: no write.
        send_header(1'b1, 16'h0300, 4'd0, HBEATS);
        send_beat(4'hF);
        bus.master_valid = 1'b0;
        wait_idle();

        // Random mix of bursts.
        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(3) == 0) ? AW'(16'hFFF8 + 16'($urandom_range(7))) : AW'($urandom_range(511));
            rl = LW'($urandom_range(15));
            for (int i = 0; i < 16; i++) wbuf[i] = DW'($urandom);
            run_txn($urandom_range(1) == 1, ra, rl);
        end

`ifdef SLAVE_SPLIT_EN
        // Reset while the transaction sits in SPLIT.
        begin
            int n;
            split_chk_en = 1'b0;
            exp_ra.push_back(16'h0040);
            send_header(1'b0, 16'h0040, 4'd0, HBEATS);
            bus.master_valid = 1'b0;
            n = 0;
            while (!bus.split && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("split_reached", {31'd0, bus.split}, 32'd1);
            #2 rstn = 1'b0;
            #1;
            check("rst_in_split_outputs", {25'd0, ram_wr_en, ram_rd_en, bus.slave_ready,
                                           bus.slave_valid, bus.split, bus.rd_bus != '0}, 32'd0);
            check("rst_in_split_addr", {16'd0, ram_addr}, 32'd0);
            exp_wr.delete();
            exp_ra.delete();
            exp_beat.delete();
            repeat (2) @(negedge clk);
            rstn = 1'b1;
            repeat (12) @(negedge clk);
        end
`endif

        check("wr_queue_drained", exp_wr.size(), 32'd0);
        check("rd_queue_drained", exp_ra.size() + exp_beat.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/slave_port_v3.md
Name: slave_port_v3

Overview:
Serial-bus slave front end for the system bus that bridges the bit-serial master link to a word-wide synchronous RAM. Generalises the single-bit, single-word slave port in three ways: LANES-bit-wide serial beats, multi-word bursts with address auto-increment, and an optional split path with explicit re-grant. Sits between the bus interconnect and one memory slave.

Parameters:
ADDR_WIDTH, 16, RAM word address width
DATA_WIDTH, 8, RAM word width
LANES, 1, serial bits per beat. DATA_WIDTH % LANES == 0 and (ADDR_WIDTH+LEN_WIDTH) % LANES == 0 are required; elaboration $error otherwise.
LEN_WIDTH, 4, burst-length field width; burst words = field+1 (1..2^LEN_WIDTH)
READ_LATENCY, 4, cycles from ram_rd_en to valid ram_in (>=1)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
mode  in  1  1=write, 0=read; sampled on the first header beat
wr_bus  in  LANES  master-to-slave serial data, MSB group first
master_valid  in  1  master beat valid
master_ready  in  1  master accepts read beat
rd_bus  out  LANES  slave-to-master serial data
slave_ready  out  1  slave accepting header/write beats
slave_valid  out  1  rd_bus beat valid
split  out  1  slave has split the transaction (SLAVE_SPLIT_EN only, else tied 0)
split_grant  in  1  bus returns grant after split (SLAVE_SPLIT_EN only)
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_wr_en  out  1  RAM write strobe
ram_rd_en  out  1  RAM read strobe
ram_rdata  in  DATA_WIDTH  RAM read data

Behaviour:
- Reset (async): state IDLE; all counters, registers and outputs 0.
- Beat accepted = master_valid & slave_ready (header/write); read beat retired = slave_valid & master_ready.
- IDLE: slave_ready=0. master_valid=1 -> HDR, latch mode.
- HDR: slave_ready=1; shifts LANES bits per accepted beat into {addr, len}; (ADDR_WIDTH+LEN_WIDTH)/LANES beats. master_valid=0 mid-header -> IDLE, nothing latched, no RAM access. Last beat -> WDATA (mode=1) or RD_ISSUE (mode=0).
- WDATA: slave_ready=1; DATA_WIDTH/LANES beats fill ram_wdata MSB first; master_valid=0 -> IDLE, no write. Last beat -> WRITE.
- WRITE: ram_wr_en=1 for exactly 1 cycle at current addr. Remaining words -> addr+1, WDATA; else IDLE.
- RD_ISSUE: ram_rd_en=1 for 1 cycle; -> RWAIT, latency counter cleared.
- RWAIT: counts READ_LATENCY cycles, then captures ram_rdata into shift register -> SEND (or SPLIT, see feature).
- SEND: slave_valid=1; rd_bus = top LANES bits of shift register; shifts on each retired beat; master_ready=0 holds data stable. Last beat retired: remaining words -> addr+1, RD_ISSUE; else IDLE.
- Address increment wraps modulo 2^ADDR_WIDTH.
- Burst counter: len field counts down; len=0 is a single word.
- ram_addr/ram_wdata are held registers, stable whenever strobes are asserted.
- Only one of ram_wr_en / ram_rd_en is ever high in a cycle.

Optional Feature:
SLAVE_SPLIT_EN
- Defined: when READ_LATENCY > 2, RWAIT -> SPLIT after issue, with split=1. Data is captured at latency expiry. The block leaves SPLIT -> SEND only on split_grant=1 after capture. split_grant before data ready is ignored.
- Undefined: no SPLIT state; split tied 0; split_grant unused.

Decomposition:
- Package slave_port_pkg: state enum typedef, width localparam functions (header beats, data beats), parameter-legality checks.
- Sub-module: serial_shift_lane (parametrised LANES-wide load/shift register), used for header, write-data and read-data paths.

Test Plan:
- LANES=1, write addr 0x0012 len 0 data 0xA5 -> 1 ram_wr_en pulse, addr 0x0012, data 0xA5; then IDLE.
- LANES=4, read burst addr 0x00FE len 2; RAM preloaded 0x11, 0x22, 0x33 -> rd_bus beats 1,1,2,2,3,3; addresses 0x00FE, 0x00FF, 0x0100.
- Write burst at addr 0xFFFF len 1 -> writes at 0xFFFF then 0x0000 (wrap).
- master_valid dropped on header beat 10 -> return to IDLE, no ram_wr_en/ram_rd_en.
- Read with master_ready low 3 cycles mid-word -> rd_bus and slave_valid held; no beat lost.
- SLAVE_SPLIT_EN, READ_LATENCY=4, grant at cycle 7 after issue -> split=1 until grant; first slave_valid on the following cycle; rstn asserted mid-SPLIT -> all outputs 0 immediately.
